// File: rtl/mips_mem_pkg.sv
// Shared encodings and helpers for the MEM-stage access controller.
package mips_mem_pkg;

  localparam int unsigned TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    SzByte = 2'b00,
    SzHalf = 2'b01,
    SzWord = 2'b10,
    SzIll  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StDone   = 2'b10,
    StErr    = 2'b11
  } state_e;

  // Both read and write set is treated like a bad address/size combination.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off,
                                         input logic rd, input logic wr);
    logic bad;
    unique case (size)
      SzByte:  bad = 1'b0;
      SzHalf:  bad = off[0];
      SzWord:  bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad | (rd & wr);
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    unique case (size)
      SzByte:  return 4'b0001 << off;
      SzHalf:  return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
    unique case (size)
      SzByte:  return {4{wd[7:0]}};
      SzHalf:  return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/Trunker.sv
// Load truncation / sign-extension of a right-justified word.
module Trunker
  import mips_mem_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [1:0]  i_size,
  input  logic        i_sign,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_data;
    unique case (i_size)
      SzByte:  o_data = {{24{i_sign & i_data[7]}}, i_data[7:0]};
      SzHalf:  o_data = {{16{i_sign & i_data[15]}}, i_data[15:0]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: alignment check, lane mapping, ack wait with timeout.
module mem_access_ctrl
  import mips_mem_pkg::*;
#(
  parameter int unsigned P_TIMEOUT = TIMEOUT_DEF
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_MAC_valid,
  input  logic        I_MAC_read,
  input  logic        I_MAC_write,
  input  logic [1:0]  I_MAC_size,
  input  logic        I_MAC_sign,
  input  logic [31:0] I_MAC_addr,
  input  logic [31:0] I_MAC_wdata,
  output logic        O_MAC_stall,
  output logic        O_MAC_done,
  output logic [31:0] O_MAC_rdata,
  output logic        O_MAC_misalign,
  output logic        O_MAC_buserr,
  output logic        O_MEM_req,
  output logic        O_MEM_we,
  output logic [31:0] O_MEM_addr,
  output logic [3:0]  O_MEM_be,
  output logic [31:0] O_MEM_wdata,
  input  logic        I_MEM_ack,
  input  logic [31:0] I_MEM_rdata
);

  localparam int unsigned CntW = $clog2(P_TIMEOUT + 1);

  state_e r_state, w_state_d;

  logic [31:0]     r_addr, r_wdata, r_rdata;
  logic [1:0]      r_size;
  logic [3:0]      r_be;
  logic            r_sign, r_we, r_err_mis;
  logic [CntW-1:0] r_cnt;

  logic        w_accept, w_misalign, w_timeout, w_ack;
  logic [31:0] w_shifted, w_ext;

  assign w_accept   = (r_state == StIdle) & I_MAC_valid & (I_MAC_read | I_MAC_write);
  assign w_misalign = is_misaligned(I_MAC_size, I_MAC_addr[1:0], I_MAC_read, I_MAC_write);
  assign w_ack      = (r_state == StAccess) & I_MEM_ack;
  assign w_timeout  = (r_cnt >= CntW'(P_TIMEOUT - 1));

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) r_state <= StIdle;
    else         r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_accept) w_state_d = w_misalign ? StErr : StAccess;
      StAccess: begin
        // Ack wins over a timeout reached in the same cycle.
        if (I_MEM_ack)      w_state_d = StDone;
        else if (w_timeout) w_state_d = StErr;
      end
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_size    <= '0;
      r_be      <= '0;
      r_sign    <= 1'b0;
      r_we      <= 1'b0;
      r_err_mis <= 1'b0;
    end else if (w_accept) begin
      r_addr    <= {I_MAC_addr[31:2], 2'b00};
      r_wdata   <= lane_wdata(I_MAC_size, I_MAC_wdata);
      r_size    <= I_MAC_size;
      r_be      <= lane_be(I_MAC_size, I_MAC_addr[1:0]);
      r_sign    <= I_MAC_sign;
      r_we      <= I_MAC_write;
      r_err_mis <= w_misalign;
    end else if ((r_state == StAccess) && !I_MEM_ack && w_timeout) begin
      r_err_mis <= 1'b0;
    end
  end

  // The low address bits are only needed for the read shift; keep them from the request.
  logic [1:0] r_off;
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset)       r_off <= '0;
    else if (w_accept) r_off <= I_MAC_addr[1:0];
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset)                   r_cnt <= '0;
    else if (r_state != StAccess)  r_cnt <= '0;
    else if (r_cnt != CntW'(P_TIMEOUT)) r_cnt <= r_cnt + CntW'(1);
  end

  assign w_shifted = I_MEM_rdata >> {r_off, 3'b000};

  Trunker u_trunker (
    .i_data (w_shifted),
    .i_size (r_size),
    .i_sign (r_sign),
    .o_data (w_ext)
  );

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset)             r_rdata <= '0;
    else if (w_ack && !r_we) r_rdata <= w_ext;
  end

  assign O_MAC_stall    = w_accept | (r_state == StAccess);
  assign O_MAC_done     = (r_state == StDone);
  assign O_MAC_rdata    = r_rdata;
  assign O_MAC_misalign = (r_state == StErr) & r_err_mis;
  assign O_MAC_buserr   = (r_state == StErr) & ~r_err_mis;
  assign O_MEM_req      = (r_state == StAccess);
  assign O_MEM_we       = (r_state == StAccess) & r_we;
  assign O_MEM_addr     = r_addr;
  assign O_MEM_be       = r_be;
  assign O_MEM_wdata    = r_wdata;

endmodule
